// File: rtl/joy_serial_reader.sv
// Reader for 74HC165-style joystick chains: drives load/shift lines and assembles
// active-high per-pad button words. Optional frame debounce: JOY_SERIAL_DEBOUNCE_EN.
module joy_serial_reader #(
   parameter int PLAYERS     = 2,
   parameter int BITS        = 12,
   parameter int CLK_DIV     = 50,
   parameter int FRAME_TICKS = 1000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic                    joy_data,
   output logic                    joy_load,
   output logic                    joy_clk,
   output logic [PLAYERS*BITS-1:0] joy_out,
   output logic                    frame_strobe
);
   localparam int NB = PLAYERS * BITS;
   localparam int TW = $clog2(CLK_DIV - 1) + 1;
   localparam int IW = $clog2(FRAME_TICKS - 1) + 1;
   localparam int NW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
   localparam logic [IW-1:0] IDLE_LAST = IW'(FRAME_TICKS - 1);
   localparam logic [NW-1:0] BIT_LAST  = NW'(NB - 1);

   typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE} state_t;

   state_t        state, state_nxt;
   logic [TW-1:0] tick_cnt, tick_nxt;
   logic [IW-1:0] idle_cnt, idle_nxt;
   logic [NW-1:0] bit_idx, bit_nxt;
   logic [NB-1:0] raw, raw_nxt, out_nxt;
   logic          tick, load_nxt, sclk_nxt, strobe_nxt, accept;

   assign tick = (tick_cnt == TICK_LAST);

`ifdef JOY_SERIAL_DEBOUNCE_EN
   logic [NB-1:0] hist;

   // Previous frame's raw (active-low) word; all-ones means nothing pressed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         hist <= '1;
      else if (en && state == DONE)
         hist <= raw;
   end

   assign accept = (raw == hist);
`else
   assign accept = 1'b1;
`endif

   always_comb begin
      state_nxt  = state;
      tick_nxt   = tick ? '0 : tick_cnt + 1'b1;
      idle_nxt   = idle_cnt;
      bit_nxt    = bit_idx;
      raw_nxt    = raw;
      out_nxt    = joy_out;
      strobe_nxt = 1'b0;
      if (!en) begin
         state_nxt = IDLE;
         tick_nxt  = '0;
         idle_nxt  = '0;
         bit_nxt   = '0;
         out_nxt   = '0;
      end else begin
         case (state)
            IDLE: if (tick) begin
               if (idle_cnt == IDLE_LAST) begin
                  idle_nxt  = '0;
                  state_nxt = LOAD;
               end else begin
                  idle_nxt = idle_cnt + 1'b1;
               end
            end
            LOAD: if (tick) begin
               bit_nxt   = '0;
               state_nxt = SHIFT_LO;
            end
            SHIFT_LO: if (tick) begin
               raw_nxt[bit_idx] = joy_data;
               state_nxt        = SHIFT_HI;
            end
            SHIFT_HI: if (tick) begin
               if (bit_idx == BIT_LAST) begin
                  bit_nxt   = '0;
                  state_nxt = DONE;
               end else begin
                  bit_nxt   = bit_idx + 1'b1;
                  state_nxt = SHIFT_LO;
               end
            end
            DONE: begin
               // Tick counter holds here so the next idle interval starts on a full tick.
               tick_nxt   = tick_cnt;
               strobe_nxt = 1'b1;
               if (accept)
                  out_nxt = ~raw;
               state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
      load_nxt = (state_nxt != LOAD);
      sclk_nxt = (state_nxt != SHIFT_LO);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         tick_cnt     <= '0;
         idle_cnt     <= '0;
         bit_idx      <= '0;
         joy_load     <= 1'b1;
         joy_clk      <= 1'b1;
         joy_out      <= '0;
         frame_strobe <= 1'b0;
      end else begin
         state        <= state_nxt;
         tick_cnt     <= tick_nxt;
         idle_cnt     <= idle_nxt;
         bit_idx      <= bit_nxt;
         joy_load     <= load_nxt;
         joy_clk      <= sclk_nxt;
         joy_out      <= out_nxt;
         frame_strobe <= strobe_nxt;
      end
   end

   always_ff @(posedge clk)
      raw <= raw_nxt;

endmodule

// File: tb/tb_joy_serial_reader.sv
// Bench for joy_serial_reader: two configurations (2x12 and 4x16) driven by
// behavioural 74HC165 chain models, with a frame-level output model.
module tb_joy_serial_reader;
   localparam int NA = 24;
   localparam int NB = 64;
`ifdef JOY_SERIAL_DEBOUNCE_EN
   localparam bit DEBOUNCE = 1'b1;
`else
   localparam bit DEBOUNCE = 1'b0;
`endif

   logic clk = 1'b0, reset = 1'b1, en = 1'b0;
   logic data_a, load_a, jclk_a, strobe_a;
   logic data_b, load_b, jclk_b, strobe_b;
   logic [NA-1:0] out_a;
   logic [NB-1:0] out_b;
   logic [NA-1:0] pressed_a = 24'h800001;
   logic [NB-1:0] pressed_b = 64'h8000_0000_0000_0000;
   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   joy_serial_reader #(.PLAYERS(2), .BITS(12), .CLK_DIV(2), .FRAME_TICKS(4)) dut_a (
      .clk(clk), .reset(reset), .en(en), .joy_data(data_a), .joy_load(load_a),
      .joy_clk(jclk_a), .joy_out(out_a), .frame_strobe(strobe_a));

   joy_serial_reader #(.PLAYERS(4), .BITS(16), .CLK_DIV(3), .FRAME_TICKS(4)) dut_b (
      .clk(clk), .reset(reset), .en(en), .joy_data(data_b), .joy_load(load_b),
      .joy_clk(jclk_b), .joy_out(out_b), .frame_strobe(strobe_b));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Chain models: parallel load while load is low, shift toward data on joy_clk rise
   logic [NA-1:0] sr_a = '1;
   logic [NB-1:0] sr_b = '1;
   logic jq_a = 1'b1, jq_b = 1'b1;
   always @(posedge clk) begin
      jq_a <= jclk_a;
      jq_b <= jclk_b;
      if (!load_a) sr_a <= ~pressed_a;
      else if (jclk_a && !jq_a) sr_a <= {1'b1, sr_a[NA-1:1]};
      if (!load_b) sr_b <= ~pressed_b;
      else if (jclk_b && !jq_b) sr_b <= {1'b1, sr_b[NB-1:1]};
   end
   assign data_a = sr_a[0];
   assign data_b = sr_b[0];

   // Frame-level output model
   logic [NA-1:0] lat_a = '0, hist_a = '0, exp_a = '0;
   logic [NB-1:0] lat_b = '0, hist_b = '0, exp_b = '0;
   logic en_seen = 1'b0;
   always @(posedge clk) en_seen <= en;

   function automatic logic [63:0] frame_out(input logic [63:0] lat, input logic [63:0] hist,
                                             input logic [63:0] cur);
      return (!DEBOUNCE || lat == hist) ? lat : cur;
   endfunction

   always @(negedge clk) begin
      if (reset) begin
         exp_a = '0; hist_a = '0; exp_b = '0; hist_b = '0;
      end else begin
         if (!load_a) lat_a = pressed_a;
         if (!load_b) lat_b = pressed_b;
         if (!en_seen) begin
            exp_a = '0;
            exp_b = '0;
            check("strobe_off_a", strobe_a, 0);
            check("strobe_off_b", strobe_b, 0);
         end else begin
            if (strobe_a) begin
               exp_a  = NA'(frame_out(lat_a, hist_a, exp_a));
               hist_a = lat_a;
            end
            if (strobe_b) begin
               exp_b  = frame_out(lat_b, hist_b, exp_b);
               hist_b = lat_b;
            end
         end
      end
      check("out_a", out_a, exp_a);
      check("out_b", out_b, exp_b);
      check("lines_a_not_both_low", load_a | jclk_a, 1);
      check("lines_b_not_both_low", load_b | jclk_b, 1);
   end

   // Frame timing monitors
   int cyc_a = 0, run_a = 0, rises_a = 0, cyc_b = 0, run_b = 0, rises_b = 0;
   bit dis_a = 1'b1, dis_b = 1'b1, jp_a = 1'b1, jp_b = 1'b1, sp_a = 1'b0, sp_b = 1'b0;
   always @(negedge clk) begin
      if (reset || !en) begin
         dis_a = 1'b1; run_a = 0; dis_b = 1'b1; run_b = 0;
      end else begin
         cyc_a++;
         if (!load_a) begin
            run_a++; rises_a = 0;
         end else begin
            if (run_a != 0) check("load_width_a", run_a, 2);
            run_a = 0;
            if (jclk_a && !jp_a) rises_a++;
         end
         if (strobe_a) begin
            check("strobe_width_a", sp_a, 0);
            check("clk_rises_a", rises_a, 24);
            if (!dis_a) check("period_a", cyc_a, 107);
            cyc_a = 0; dis_a = 1'b0;
         end
         cyc_b++;
         if (!load_b) begin
            run_b++; rises_b = 0;
         end else begin
            if (run_b != 0) check("load_width_b", run_b, 3);
            run_b = 0;
            if (jclk_b && !jp_b) rises_b++;
         end
         if (strobe_b) begin
            check("strobe_width_b", sp_b, 0);
            check("clk_rises_b", rises_b, 64);
            if (!dis_b) check("period_b", cyc_b, 400);
            cyc_b = 0; dis_b = 1'b0;
         end
      end
      jp_a = jclk_a; sp_a = strobe_a; jp_b = jclk_b; sp_b = strobe_b;
   end

   task automatic wait_strobe(input bit which, input string name);
      bit found = 1'b0;
      for (int i = 0; i < 1500 && !found; i++) begin
         @(posedge clk); #1;
         if (which ? strobe_b : strobe_a) found = 1'b1;
      end
      if (!found) check({name, "_strobe_timeout"}, found, 1);
   endtask

   task automatic cycles_to_load(output int n);
      bit found = 1'b0;
      n = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(posedge clk); #1;
         n++;
         if (!load_a) found = 1'b1;
      end
      if (!found) check("load_timeout", found, 1);
   endtask

   task automatic wait_jclk_a(input bit rising, input int count);
      int seen = 0;
      logic prev = jclk_a;
      for (int i = 0; i < 500 && seen < count; i++) begin
         @(posedge clk); #1;
         if (jclk_a != prev && jclk_a == rising) seen++;
         prev = jclk_a;
      end
      if (seen < count) check("jclk_timeout", seen, count);
   endtask

   initial begin
      int n;
      int strobes;
      repeat (3) @(posedge clk);
      #1;
      check("rst_load_a", load_a, 1);
      check("rst_clk_a", jclk_a, 1);
      check("rst_out_a", out_a, 0);
      check("rst_strobe_a", strobe_a, 0);
      check("rst_out_b", out_b, 0);
      en = 1'b1;
      @(negedge clk); reset = 1'b0;

      cycles_to_load(n);
      check("first_load_delay", n, 8);
      wait_strobe(0, "f1");
      check("f1_out", out_a, DEBOUNCE ? 24'h0 : 24'h800001);
      wait_strobe(0, "f2");
      check("f2_out", out_a, 24'h800001);

      // Reset during SHIFT_LO of bit 7
      cycles_to_load(n);
      wait_jclk_a(1'b0, 8);
      #2 reset = 1'b1;
      #1;
      check("midrst_load", load_a, 1);
      check("midrst_clk", jclk_a, 1);
      check("midrst_out", out_a, 0);
      @(negedge clk); @(negedge clk); reset = 1'b0;
      cycles_to_load(n);
      check("rst_release_load_delay", n, 8);
      wait_strobe(0, "r1");
      check("r1_out", out_a, DEBOUNCE ? 24'h0 : 24'h800001);

      // Drop en after 10 shifted bits
      cycles_to_load(n);
      wait_jclk_a(1'b1, 10);
      en = 1'b0;
      strobes = 0;
      repeat (300) begin
         @(posedge clk); #1;
         if (strobe_a) strobes++;
      end
      check("en_off_strobes", strobes, 0);
      check("en_off_out", out_a, 0);
      check("en_off_load", load_a, 1);
      check("en_off_clk", jclk_a, 1);
      en = 1'b1;
      cycles_to_load(n);
      check("en_on_load_delay", n, 8);
      wait_strobe(0, "e1");
      check("en_on_out", out_a, 24'h800001);

      // Single-frame press vs held press of pad0 bit3
      pressed_a = '0;
      wait_strobe(0, "p1");
      wait_strobe(0, "p2");
      check("p2_out", out_a, 0);
      pressed_a = 24'h000008;
      wait_strobe(0, "s1");
      check("s1_out", out_a, DEBOUNCE ? 24'h0 : 24'h000008);
      pressed_a = '0;
      wait_strobe(0, "s2");
      check("s2_out", out_a, 0);
      pressed_a = 24'h000008;
      wait_strobe(0, "s3");
      check("s3_out", out_a, DEBOUNCE ? 24'h0 : 24'h000008);
      wait_strobe(0, "s4");
      check("s4_out", out_a, 24'h000008);

      // 4x16 configuration: pad3 bit15
      wait_strobe(1, "g1");
      wait_strobe(1, "g2");
      check("gen_out", out_b, 64'h8000_0000_0000_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
